// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath widths, ALU op codes, load/store
// funct3 codes and the EX/MEM pipeline payload.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RA_W = 5;

  typedef enum logic [3:0] {
    ADD  = 4'b0000,
    SUB  = 4'b0001,
    SLL  = 4'b0010,
    SLT  = 4'b0011,
    SLTU = 4'b0100,
    XOR  = 4'b0101,
    SRL  = 4'b0110,
    SRA  = 4'b0111,
    OR   = 4'b1000,
    AND  = 4'b1001
  } alu_op_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    TRAP_IDLE    = 1'b0,
    TRAP_PENDING = 1'b1
  } trap_state_t;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            zero;
    logic            carry;
    logic [RA_W-1:0] rd;
    logic [2:0]      funct3;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] pc;
  } ex_mem_t;

endpackage

// File: rtl/ex_mem_reg_if.sv
// EX->MEM bundle: execute-stage inputs, registered memory-stage outputs,
// forwarding source and overflow-trap status.
interface ex_mem_reg_if #(
  parameter int unsigned XLEN = riscv_pkg::XLEN,
  parameter int unsigned RA_W = riscv_pkg::RA_W
);

  logic            ex_valid_i;
  logic [XLEN-1:0] ex_result_i;
  logic            ex_zero_i;
  logic            ex_carry_i;
  logic            ex_overflow_i;
  logic [RA_W-1:0] ex_rd_i;
  logic            ex_reg_write_i;
  logic            ex_mem_read_i;
  logic            ex_mem_write_i;
  logic [XLEN-1:0] ex_store_data_i;
  logic [2:0]      ex_funct3_i;
  logic [XLEN-1:0] ex_pc_i;
  logic            ex_ovf_trap_en_i;

  logic            mem_valid_o;
  logic            mem_reg_write_o;
  logic            mem_mem_read_o;
  logic            mem_mem_write_o;
  logic [XLEN-1:0] mem_result_o;
  logic [XLEN-1:0] mem_store_data_o;
  logic [XLEN-1:0] mem_pc_o;
  logic            mem_zero_o;
  logic            mem_carry_o;
  logic [RA_W-1:0] mem_rd_o;
  logic [2:0]      mem_funct3_o;

  logic            fwd_valid_o;
  logic [RA_W-1:0] fwd_rd_o;
  logic [XLEN-1:0] fwd_data_o;

  logic            trap_pending_o;
  logic [XLEN-1:0] trap_pc_o;

  modport master (
    output ex_valid_i, ex_result_i, ex_zero_i, ex_carry_i, ex_overflow_i,
           ex_rd_i, ex_reg_write_i, ex_mem_read_i, ex_mem_write_i,
           ex_store_data_i, ex_funct3_i, ex_pc_i, ex_ovf_trap_en_i,
    input  mem_valid_o, mem_reg_write_o, mem_mem_read_o, mem_mem_write_o,
           mem_result_o, mem_store_data_o, mem_pc_o, mem_zero_o, mem_carry_o,
           mem_rd_o, mem_funct3_o, fwd_valid_o, fwd_rd_o, fwd_data_o,
           trap_pending_o, trap_pc_o
  );

  modport slave (
    input  ex_valid_i, ex_result_i, ex_zero_i, ex_carry_i, ex_overflow_i,
           ex_rd_i, ex_reg_write_i, ex_mem_read_i, ex_mem_write_i,
           ex_store_data_i, ex_funct3_i, ex_pc_i, ex_ovf_trap_en_i,
    output mem_valid_o, mem_reg_write_o, mem_mem_read_o, mem_mem_write_o,
           mem_result_o, mem_store_data_o, mem_pc_o, mem_zero_o, mem_carry_o,
           mem_rd_o, mem_funct3_o, fwd_valid_o, fwd_rd_o, fwd_data_o,
           trap_pending_o, trap_pc_o
  );

endinterface

// File: rtl/ex_mem_reg_ovf_trap_latch.sv
// Sticky overflow-trap latch: holds the PC of the first unacknowledged trap;
// a new trap arriving with the acknowledge replaces it.
module ovf_trap_latch #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_i,
  input  logic [XLEN-1:0] set_pc_i,
  input  logic            ack_i,
  output logic            pending_o,
  output logic [XLEN-1:0] pc_o
);
  import riscv_pkg::*;

  trap_state_t     state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= TRAP_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Set beats ack; a set while still pending keeps the first PC.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (set_i && (state_q == TRAP_IDLE || ack_i)) begin
      state_d = TRAP_PENDING;
      pc_d    = set_pc_i;
    end else if (ack_i) begin
      state_d = TRAP_IDLE;
    end
  end

  assign pending_o = (state_q == TRAP_PENDING);
  assign pc_o      = pc_q;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/flush, write suppression for trapping
// ops, EX/MEM forwarding source and overflow-trap latch.
module ex_mem_reg #(
  parameter int unsigned XLEN = riscv_pkg::XLEN,
  parameter int unsigned RA_W = riscv_pkg::RA_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            trap_ack_i,
  ex_mem_reg_if.slave     bus
);
  import riscv_pkg::*;

  ex_mem_t cur_q, nxt;
  logic    capture;
  logic    trap_hit;

  assign capture  = !flush_i && !stall_i;
  assign trap_hit = capture && bus.ex_valid_i && bus.ex_ovf_trap_en_i
                    && bus.ex_overflow_i;

  always_comb begin
    nxt = cur_q;
    if (flush_i) begin
      nxt.valid     = 1'b0;
      nxt.reg_write = 1'b0;
      nxt.mem_read  = 1'b0;
      nxt.mem_write = 1'b0;
    end else if (!stall_i) begin
      nxt.valid      = bus.ex_valid_i;
      // Trapping op still flows to MEM but must not change architectural state.
      nxt.reg_write  = bus.ex_valid_i && bus.ex_reg_write_i
                       && (bus.ex_rd_i != RA_W'(0)) && !trap_hit;
      nxt.mem_read   = bus.ex_valid_i && bus.ex_mem_read_i;
      nxt.mem_write  = bus.ex_valid_i && bus.ex_mem_write_i && !trap_hit;
      nxt.zero       = bus.ex_zero_i;
      nxt.carry      = bus.ex_carry_i;
      nxt.rd         = bus.ex_rd_i;
      nxt.funct3     = bus.ex_funct3_i;
      nxt.result     = bus.ex_result_i;
      nxt.store_data = bus.ex_store_data_i;
      nxt.pc         = bus.ex_pc_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cur_q <= '0;
    else        cur_q <= nxt;
  end

  ovf_trap_latch #(.XLEN(XLEN)) u_trap (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_i     (trap_hit),
    .set_pc_i  (bus.ex_pc_i),
    .ack_i     (trap_ack_i),
    .pending_o (bus.trap_pending_o),
    .pc_o      (bus.trap_pc_o)
  );

  assign bus.mem_valid_o      = cur_q.valid;
  assign bus.mem_reg_write_o  = cur_q.reg_write;
  assign bus.mem_mem_read_o   = cur_q.mem_read;
  assign bus.mem_mem_write_o  = cur_q.mem_write;
  assign bus.mem_zero_o       = cur_q.zero;
  assign bus.mem_carry_o      = cur_q.carry;
  assign bus.mem_rd_o         = cur_q.rd;
  assign bus.mem_funct3_o     = cur_q.funct3;
  assign bus.mem_result_o     = cur_q.result;
  assign bus.mem_store_data_o = cur_q.store_data;
  assign bus.mem_pc_o         = cur_q.pc;

  // Loads are not forwarded from here: their data only exists after MEM.
  assign bus.fwd_valid_o = cur_q.valid && cur_q.reg_write && !cur_q.mem_read
                           && (cur_q.rd != RA_W'(0));
  assign bus.fwd_rd_o    = cur_q.rd;
  assign bus.fwd_data_o  = cur_q.result;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: reset, capture, forwarding, stall/flush,
// loads/stores and overflow-trap latching.
module tb_ex_mem_reg;

  logic clk = 1'b0;
  logic rst_n, stall_i, flush_i, trap_ack_i;
  int   checks = 0;
  int   errors = 0;

  ex_mem_reg_if #(.XLEN(32), .RA_W(5)) bus ();

  ex_mem_reg #(.XLEN(32), .RA_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .trap_ack_i (trap_ack_i),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw,
                       input logic [31:0] pc);
    bus.ex_valid_i     = v;
    bus.ex_result_i    = res;
    bus.ex_rd_i        = rd;
    bus.ex_reg_write_i = rw;
    bus.ex_mem_read_i  = mr;
    bus.ex_mem_write_i = mw;
    bus.ex_pc_i        = pc;
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; trap_ack_i = 1'b0;
    bus.ex_zero_i = 1'b0; bus.ex_carry_i = 1'b0; bus.ex_overflow_i = 1'b0;
    bus.ex_store_data_i = 32'h0; bus.ex_funct3_i = 3'b000; bus.ex_ovf_trap_en_i = 1'b0;
    drive(1'b1, 32'd5, 5'd3, 1'b1, 1'b0, 1'b0, 32'h8);

    // Reset with a valid instruction presented
    edge_step();
    chk("rst_valid", bus.mem_valid_o, 0);
    chk("rst_result", bus.mem_result_o, 0);
    chk("rst_fwd_valid", bus.fwd_valid_o, 0);
    chk("rst_trap", bus.trap_pending_o, 0);

    // ADD capture and forwarding
    rst_n = 1'b1;
    drive(1'b1, 32'd4, 5'd5, 1'b1, 1'b0, 1'b0, 32'h10);
    edge_step();
    chk("add_valid", bus.mem_valid_o, 1);
    chk("add_result", bus.mem_result_o, 4);
    chk("add_pc", bus.mem_pc_o, 32'h10);
    chk("add_fwd_valid", bus.fwd_valid_o, 1);
    chk("add_fwd_rd", bus.fwd_rd_o, 5);
    chk("add_fwd_data", bus.fwd_data_o, 4);

    // rd = x0 never writes nor forwards
    drive(1'b1, 32'd4, 5'd0, 1'b1, 1'b0, 1'b0, 32'h14);
    edge_step();
    chk("x0_reg_write", bus.mem_reg_write_o, 0);
    chk("x0_fwd_valid", bus.fwd_valid_o, 0);

    // SUB result 1, then stall three cycles with changing inputs
    drive(1'b1, 32'd1, 5'd6, 1'b1, 1'b0, 1'b0, 32'h18);
    edge_step();
    chk("sub_result", bus.mem_result_o, 1);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'd99 + 32'(i), 5'd9, 1'b1, 1'b0, 1'b0, 32'h1C + 32'(4 * i));
      edge_step();
      chk("stall_result", bus.mem_result_o, 1);
      chk("stall_rd", bus.mem_rd_o, 6);
      chk("stall_pc", bus.mem_pc_o, 32'h18);
    end

    // Flush wins over stall
    flush_i = 1'b1;
    edge_step();
    chk("flush_valid", bus.mem_valid_o, 0);
    chk("flush_reg_write", bus.mem_reg_write_o, 0);
    chk("flush_fwd_valid", bus.fwd_valid_o, 0);

    // Release: next instruction captured exactly once
    flush_i = 1'b0; stall_i = 1'b0;
    drive(1'b1, 32'h22, 5'd8, 1'b1, 1'b0, 1'b0, 32'h20);
    edge_step();
    chk("rel_valid", bus.mem_valid_o, 1);
    chk("rel_result", bus.mem_result_o, 32'h22);
    chk("rel_rd", bus.mem_rd_o, 8);
    drive(1'b0, 32'h22, 5'd8, 1'b1, 1'b0, 1'b0, 32'h20);
    edge_step();
    chk("rel_bubble_valid", bus.mem_valid_o, 0);
    chk("rel_bubble_rw", bus.mem_reg_write_o, 0);

    // Load: not forwarded
    drive(1'b1, 32'h1000, 5'd7, 1'b1, 1'b1, 1'b0, 32'h24);
    bus.ex_funct3_i = 3'b010;
    edge_step();
    chk("ld_mem_read", bus.mem_mem_read_o, 1);
    chk("ld_reg_write", bus.mem_reg_write_o, 1);
    chk("ld_funct3", bus.mem_funct3_o, 3'b010);
    chk("ld_fwd_valid", bus.fwd_valid_o, 0);

    // Store with flags
    drive(1'b1, 32'h2000, 5'd0, 1'b0, 1'b0, 1'b1, 32'h28);
    bus.ex_store_data_i = 32'hDEAD; bus.ex_zero_i = 1'b1; bus.ex_carry_i = 1'b1;
    bus.ex_funct3_i = 3'b001;
    edge_step();
    chk("st_mem_write", bus.mem_mem_write_o, 1);
    chk("st_data", bus.mem_store_data_o, 32'hDEAD);
    chk("st_zero", bus.mem_zero_o, 1);
    chk("st_carry", bus.mem_carry_o, 1);
    bus.ex_zero_i = 1'b0; bus.ex_carry_i = 1'b0;

    // Overflow trap: 7FFFFFFF + 1
    drive(1'b1, 32'h8000_0000, 5'd5, 1'b1, 1'b0, 1'b0, 32'h100);
    bus.ex_overflow_i = 1'b1; bus.ex_ovf_trap_en_i = 1'b1; bus.ex_carry_i = 1'b0;
    edge_step();
    chk("trap1_pending", bus.trap_pending_o, 1);
    chk("trap1_pc", bus.trap_pc_o, 32'h100);
    chk("trap1_valid", bus.mem_valid_o, 1);
    chk("trap1_reg_write", bus.mem_reg_write_o, 0);
    chk("trap1_result", bus.mem_result_o, 32'h8000_0000);
    chk("trap1_fwd_valid", bus.fwd_valid_o, 0);

    // Second trapping store: first PC retained, store suppressed
    drive(1'b1, 32'h8000_0004, 5'd6, 1'b0, 1'b0, 1'b1, 32'h104);
    edge_step();
    chk("trap2_pending", bus.trap_pending_o, 1);
    chk("trap2_pc", bus.trap_pc_o, 32'h100);
    chk("trap2_mem_write", bus.mem_mem_write_o, 0);

    // Acknowledge alone
    drive(1'b1, 32'h3, 5'd4, 1'b1, 1'b0, 1'b0, 32'h108);
    bus.ex_overflow_i = 1'b0;
    trap_ack_i = 1'b1;
    edge_step();
    chk("ack_pending", bus.trap_pending_o, 0);
    chk("ack_reg_write", bus.mem_reg_write_o, 1);
    trap_ack_i = 1'b0;

    // New trap pending, then ack coincident with another trap
    drive(1'b1, 32'h8000_0000, 5'd5, 1'b1, 1'b0, 1'b0, 32'h1F0);
    bus.ex_overflow_i = 1'b1;
    edge_step();
    chk("trap3_pc", bus.trap_pc_o, 32'h1F0);
    drive(1'b1, 32'h8000_0000, 5'd5, 1'b1, 1'b0, 1'b0, 32'h200);
    trap_ack_i = 1'b1;
    edge_step();
    chk("ackset_pending", bus.trap_pending_o, 1);
    chk("ackset_pc", bus.trap_pc_o, 32'h200);

    // Ack during stall clears; stalled overflow is not detected
    stall_i = 1'b1;
    drive(1'b1, 32'h8000_0000, 5'd5, 1'b1, 1'b0, 1'b0, 32'h300);
    edge_step();
    chk("stall_ack_pending", bus.trap_pending_o, 0);
    chk("stall_ack_pc", bus.trap_pc_o, 32'h200);
    trap_ack_i = 1'b0; stall_i = 1'b0;

    // Reset mid-trap and mid-stall
    edge_step();
    chk("trap4_pending", bus.trap_pending_o, 1);
    chk("trap4_pc", bus.trap_pc_o, 32'h300);
    rst_n = 1'b0; stall_i = 1'b1;
    edge_step();
    chk("rst2_pending", bus.trap_pending_o, 0);
    chk("rst2_pc", bus.trap_pc_o, 0);
    chk("rst2_valid", bus.mem_valid_o, 0);
    chk("rst2_result", bus.mem_result_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
